// File: rtl/register_file_sb.sv
// register_file_sb: parametrised multi-port register file for the decode and
// writeback stages. Combinational reads with optional same-cycle write bypass,
// prioritised synchronous writes (highest port index wins), and a per-register
// busy scoreboard so decode can stall on RAW hazards.
module register_file_sb #(
  parameter int DataWidth     = 32,
  parameter int NumRegs       = 32,
  parameter int AddrWidth     = $clog2(NumRegs),
  parameter int NumReadPorts  = 2,
  parameter int NumWritePorts = 2,
  parameter int Bypass        = 1
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [NumReadPorts-1:0][AddrWidth-1:0]  read_addr,
  output logic [NumReadPorts-1:0][DataWidth-1:0]  read_data,
  output logic [NumReadPorts-1:0]                 read_busy,
  input  logic [NumWritePorts-1:0]                write_enable,
  input  logic [NumWritePorts-1:0][AddrWidth-1:0] write_addr,
  input  logic [NumWritePorts-1:0][DataWidth-1:0] write_data,
  input  logic                                    reserve_enable,
  input  logic [AddrWidth-1:0]                    reserve_addr,
  input  logic                                    flush
);

  // One extra bit so NumRegs itself is representable when it is a power of 2.
  localparam logic [AddrWidth:0] NumRegsExt = (AddrWidth + 1)'(NumRegs);

  logic [DataWidth-1:0] regs_r     [NumRegs];
  logic [NumRegs-1:0]   busy_r;
  logic [NumRegs-1:0]   wr_hit_s;
  logic [DataWidth-1:0] wr_val_s   [NumRegs];
  logic [NumRegs-1:0]   busy_nxt_s;
  logic                 rsv_valid_s;

  // Per-register write select; later (higher-index) ports override earlier ones.
  // Register 0 and out-of-range addresses never match, so those writes vanish.
  always_comb begin
    for (int i = 0; i < NumRegs; i++) begin
      wr_hit_s[i] = 1'b0;
      wr_val_s[i] = '0;
      for (int k = 0; k < NumWritePorts; k++) begin
        if (write_enable[k] && (i != 0) && (write_addr[k] == AddrWidth'(i))) begin
          wr_hit_s[i] = 1'b1;
          wr_val_s[i] = write_data[k];
        end else begin
          // no match on this port: keep the selection made by lower ports
        end
      end
    end
  end

  // A reservation is only meaningful for an in-range, non-zero register.
  always_comb begin
    rsv_valid_s = 1'b0;
    if (reserve_enable && (reserve_addr != '0) && ({1'b0, reserve_addr} < NumRegsExt)) begin
      rsv_valid_s = 1'b1;
    end else begin
      rsv_valid_s = 1'b0;
    end
  end

  // Next busy vector: writes retire producers, a new reservation marks a
  // pending producer (beating a same-cycle write), flush wipes everything.
  always_comb begin
    busy_nxt_s = busy_r & ~wr_hit_s;
    if (flush) begin
      busy_nxt_s = '0;
    end else if (rsv_valid_s) begin
      busy_nxt_s[reserve_addr] = 1'b1;
    end else begin
      // no flush and no reservation: only write retirements apply
    end
  end

  // Architectural state: register contents and busy bits, async active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_r[i] <= '0;
      end
      busy_r <= '0;
    end else begin
      for (int i = 0; i < NumRegs; i++) begin
        if (wr_hit_s[i]) begin
          regs_r[i] <= wr_val_s[i];
        end else begin
          regs_r[i] <= regs_r[i];
        end
      end
      busy_r <= busy_nxt_s;
    end
  end

  // Combinational read ports: x0, out-of-range and reset all read as zero/idle;
  // with bypass enabled a same-cycle write is forwarded and reported not busy.
  always_comb begin
    for (int p = 0; p < NumReadPorts; p++) begin
      read_data[p] = '0;
      read_busy[p] = 1'b0;
      if (rst && (read_addr[p] != '0) && ({1'b0, read_addr[p]} < NumRegsExt)) begin
        read_data[p] = regs_r[read_addr[p]];
        read_busy[p] = busy_r[read_addr[p]];
        for (int k = 0; k < NumWritePorts; k++) begin
          if ((Bypass != 0) && write_enable[k] && (write_addr[k] == read_addr[p])) begin
            read_data[p] = write_data[k];
            read_busy[p] = 1'b0;
          end else begin
            // this port does not forward to this read
          end
        end
      end else begin
        read_data[p] = '0;
        read_busy[p] = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_register_file_sb.sv
// tb_register_file_sb: scoreboard bench for register_file_sb. Two instances
// (bypass on / bypass off) share all stimulus; expected read results are
// queued as stimulus is driven and compared at the falling edge.
module tb_register_file_sb;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [1:0][4:0]      read_addr;
  logic [1:0][31:0]     data_b, data_nb;
  logic [1:0]           busy_b, busy_nb;
  logic [1:0]           write_enable;
  logic [1:0][4:0]      write_addr;
  logic [1:0][31:0]     write_data;
  logic                 reserve_enable;
  logic [4:0]           reserve_addr;
  logic                 flush;

  typedef struct {
    string       tag;
    int          inst;
    int          port;
    bit          is_busy;
    logic [31:0] val;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model [32];

  register_file_sb #(.Bypass(1)) u_dut_byp (
    .clk(clk), .rst(rst), .read_addr(read_addr), .read_data(data_b), .read_busy(busy_b),
    .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
    .reserve_enable(reserve_enable), .reserve_addr(reserve_addr), .flush(flush));

  register_file_sb #(.Bypass(0)) u_dut_nobyp (
    .clk(clk), .rst(rst), .read_addr(read_addr), .read_data(data_nb), .read_busy(busy_nb),
    .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
    .reserve_enable(reserve_enable), .reserve_addr(reserve_addr), .flush(flush));

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Overall time limit so the run can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached (checks %0d)", checks);
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push_rd(input string tag, input int inst, input int port,
                         input logic [31:0] d, input logic b);
    exp_t e;
    string nm;
    nm        = $sformatf("%s_%s_p%0d", tag, (inst == 0) ? "byp" : "nobyp", port);
    e.inst    = inst;
    e.port    = port;
    e.tag     = {nm, "_data"};
    e.is_busy = 1'b0;
    e.val     = d;
    sb_q.push_back(e);
    e.tag     = {nm, "_busy"};
    e.is_busy = 1'b1;
    e.val     = {31'd0, b};
    sb_q.push_back(e);
  endtask

  task automatic push_both(input string tag, input int port, input logic [31:0] d, input logic b);
    push_rd(tag, 0, port, d, b);
    push_rd(tag, 1, port, d, b);
  endtask

  // Drain the scoreboard against the outputs, away from the rising edge.
  task automatic sample();
    exp_t        e;
    logic [31:0] obs;
    @(negedge clk);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.inst == 0) obs = e.is_busy ? {31'd0, busy_b[e.port]}  : data_b[e.port];
      else             obs = e.is_busy ? {31'd0, busy_nb[e.port]} : data_nb[e.port];
      check_eq(e.tag, obs, e.val);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    write_enable   = 2'b00;
    reserve_enable = 1'b0;
    reserve_addr   = 5'd0;
    flush          = 1'b0;
  endtask

  initial begin
    logic [31:0] v;
    rst        = 1'b0;
    read_addr  = '0;
    write_addr = '0;
    write_data = '0;
    idle();
    for (int i = 0; i < 32; i++) model[i] = 32'd0;

    // ---------------- reset ----------------
    step();
    read_addr[0] = 5'd5;
    push_both("rst_init", 0, 32'd0, 1'b0);
    sample();
    step();
    rst = 1'b1;

    write_enable  = 2'b01;
    write_addr[0] = 5'd5;
    write_data[0] = 32'hDEADBEEF;
    push_rd("rst_wr", 0, 0, 32'hDEADBEEF, 1'b0);
    push_rd("rst_wr", 1, 0, 32'd0, 1'b0);
    sample();
    step();
    idle();
    push_both("rst_pre", 0, 32'hDEADBEEF, 1'b0);
    sample();

    // reset mid-operation, with a write to x6 that must be discarded
    rst           = 1'b0;
    write_enable  = 2'b10;
    write_addr[1] = 5'd6;
    write_data[1] = 32'h00001234;
    read_addr[1]  = 5'd6;
    push_both("rst_hold1", 0, 32'd0, 1'b0);
    push_both("rst_hold1", 1, 32'd0, 1'b0);
    sample();
    step();
    push_both("rst_hold2", 0, 32'd0, 1'b0);
    sample();
    step();
    rst = 1'b1;
    idle();
    push_both("rst_rel", 0, 32'd0, 1'b0);
    push_both("rst_rel", 1, 32'd0, 1'b0);
    sample();
    step();
    read_addr[0] = 5'd6;
    read_addr[1] = 5'd5;
    push_both("rst_rel2", 0, 32'd0, 1'b0);
    push_both("rst_rel2", 1, 32'd0, 1'b0);
    sample();
    step();

    // ---------------- fill and readback ----------------
    for (int i = 0; i < 32; i++) begin
      v             = $urandom;
      model[i]      = (i == 0) ? 32'd0 : v;
      write_enable  = 2'b01;
      write_addr[0] = 5'(i);
      write_data[0] = v;
      step();
    end
    idle();
    for (int i = 0; i < 32; i++) begin
      read_addr[0] = 5'(i);
      read_addr[1] = 5'(31 - i);
      push_both($sformatf("fill_x%0d", i), 0, model[i], 1'b0);
      push_both($sformatf("fill_x%0d", 31 - i), 1, model[31 - i], 1'b0);
      sample();
      step();
    end

    // ---------------- write priority ----------------
    write_enable  = 2'b11;
    write_addr[0] = 5'd7;
    write_addr[1] = 5'd7;
    write_data[0] = 32'h11111111;
    write_data[1] = 32'h22222222;
    read_addr[0]  = 5'd7;
    push_rd("prio_same", 0, 0, 32'h22222222, 1'b0);
    push_rd("prio_same", 1, 0, model[7], 1'b0);
    sample();
    step();
    model[7] = 32'h22222222;
    idle();
    push_both("prio_next", 0, model[7], 1'b0);
    sample();
    step();

    // ---------------- bypass ----------------
    write_enable  = 2'b01;
    write_addr[0] = 5'd9;
    write_data[0] = 32'hA5A5A5A5;
    read_addr[1]  = 5'd9;
    push_rd("byp_same", 0, 1, 32'hA5A5A5A5, 1'b0);
    push_rd("byp_same", 1, 1, model[9], 1'b0);
    sample();
    step();
    model[9] = 32'hA5A5A5A5;
    idle();
    push_both("byp_next", 1, model[9], 1'b0);
    sample();
    step();

    // ---------------- scoreboard ----------------
    reserve_enable = 1'b1;
    reserve_addr   = 5'd3;
    read_addr[0]   = 5'd3;
    push_both("sb_rsv_same", 0, model[3], 1'b0);
    sample();
    step();
    idle();
    push_both("sb_rsv_next", 0, model[3], 1'b1);
    sample();
    step();

    write_enable  = 2'b10;
    write_addr[1] = 5'd3;
    write_data[1] = 32'h33333333;
    push_rd("sb_wr_same", 0, 0, 32'h33333333, 1'b0);
    push_rd("sb_wr_same", 1, 0, model[3], 1'b1);
    sample();
    step();
    model[3] = 32'h33333333;
    idle();
    push_both("sb_wr_next", 0, model[3], 1'b0);
    sample();
    step();

    reserve_enable = 1'b1;
    reserve_addr   = 5'd3;
    write_enable   = 2'b01;
    write_addr[0]  = 5'd3;
    write_data[0]  = 32'h3C3C3C3C;
    push_rd("sb_rw_same", 0, 0, 32'h3C3C3C3C, 1'b0);
    push_rd("sb_rw_same", 1, 0, model[3], 1'b0);
    sample();
    step();
    model[3] = 32'h3C3C3C3C;
    idle();
    push_both("sb_rw_next", 0, model[3], 1'b1);
    sample();
    step();

    reserve_enable = 1'b1;
    reserve_addr   = 5'd0;
    write_enable   = 2'b10;
    write_addr[1]  = 5'd0;
    write_data[1]  = 32'hFFFFFFFF;
    read_addr[1]   = 5'd0;
    push_both("sb_x0_same", 1, 32'd0, 1'b0);
    sample();
    step();
    idle();
    push_both("sb_x0_next", 1, 32'd0, 1'b0);
    sample();
    step();

    // ---------------- flush ----------------
    reserve_enable = 1'b1;
    reserve_addr   = 5'd4;
    step();
    reserve_addr   = 5'd5;
    step();
    reserve_addr   = 5'd6;
    read_addr[0]   = 5'd4;
    read_addr[1]   = 5'd5;
    push_both("fl_pre", 0, model[4], 1'b1);
    push_both("fl_pre", 1, model[5], 1'b1);
    sample();
    step();

    reserve_enable = 1'b1;
    reserve_addr   = 5'd8;
    flush          = 1'b1;
    write_enable   = 2'b10;
    write_addr[1]  = 5'd10;
    write_data[1]  = 32'h10101010;
    read_addr[0]   = 5'd6;
    read_addr[1]   = 5'd3;
    push_both("fl_same", 0, model[6], 1'b1);
    push_both("fl_same", 1, model[3], 1'b1);
    sample();
    step();
    model[10] = 32'h10101010;
    idle();
    read_addr[0] = 5'd4;
    read_addr[1] = 5'd8;
    push_both("fl_next_a", 0, model[4], 1'b0);
    push_both("fl_next_a", 1, model[8], 1'b0);
    sample();
    step();
    read_addr[0] = 5'd5;
    read_addr[1] = 5'd6;
    push_both("fl_next_b", 0, model[5], 1'b0);
    push_both("fl_next_b", 1, model[6], 1'b0);
    sample();
    step();
    read_addr[0] = 5'd3;
    read_addr[1] = 5'd10;
    push_both("fl_next_c", 0, model[3], 1'b0);
    push_both("fl_next_c", 1, model[10], 1'b0);
    sample();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
